// File: rtl/tcdm_banked_xbar.sv
// Multi-port banked TCDM: per-bank round-robin crossbar over word-interleaved SRAM banks.
// Define TCDM_CONFLICT_CNT_EN to build the per-port saturating conflict (stall) counters.
module tcdm_banked_xbar #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned TCDMDepth = 64,
  parameter int unsigned NrBanks   = 8,
  parameter int unsigned NumInp    = 2,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned AddrWidth = $clog2(NrBanks * TCDMDepth * DataWidth / 8)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumInp-1:0]                    tcdm_req_q_valid_i,
  input  logic [NumInp-1:0]                    tcdm_req_write_i,
  input  logic [NumInp-1:0][AddrWidth-1:0]     tcdm_req_addr_i,
  input  logic [NumInp-1:0][DataWidth-1:0]     tcdm_req_data_i,
  input  logic [NumInp-1:0][DataWidth/8-1:0]   tcdm_req_strb_i,
  output logic [NumInp-1:0]                    tcdm_req_q_ready_o,
  output logic [NumInp-1:0]                    tcdm_rsp_p_valid_o,
  output logic [NumInp-1:0][DataWidth-1:0]     tcdm_rsp_data_o,
  output logic [NumInp-1:0][CntWidth-1:0]      tcdm_conflict_cnt_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ByteOff   = $clog2(StrbWidth);
  localparam int unsigned BankW     = $clog2(NrBanks);
  localparam int unsigned RowW      = $clog2(TCDMDepth);
  localparam int unsigned PtrW      = (NumInp > 1) ? $clog2(NumInp) : 1;

  logic [NumInp-1:0][BankW-1:0]  req_bank;
  logic [NumInp-1:0][RowW-1:0]   req_row;
  logic [NrBanks-1:0]            bank_gnt;
  logic [NrBanks-1:0][PtrW-1:0]  bank_win;
  logic [NrBanks-1:0][PtrW-1:0]  rr_q;
  logic [NrBanks-1:0][PtrW-1:0]  rr_d;
  logic [DataWidth-1:0]          mem [NrBanks][TCDMDepth];

  // Word-interleaved decode: bank from the lowest word-address bits, row above them
  always_comb begin
    req_bank = '0;
    req_row  = '0;
    for (int i = 0; i < NumInp; i++) begin
      req_bank[i] = tcdm_req_addr_i[i][ByteOff +: BankW];
      req_row[i]  = tcdm_req_addr_i[i][ByteOff + BankW +: RowW];
    end
  end

  // Byte-offset bits carry no information for word-aligned accesses
  if (ByteOff > 0) begin : g_lsb
    logic [NumInp-1:0] unused_addr_lsb;
    for (genvar i = 0; i < NumInp; i++) begin : g_port
      assign unused_addr_lsb[i] = ^tcdm_req_addr_i[i][ByteOff-1:0];
    end
  end

  // Per-bank round-robin: first valid requester at or after rr_q wins
  always_comb begin
    int unsigned idx;
    idx      = 0;
    bank_gnt = '0;
    bank_win = '0;
    rr_d     = rr_q;
    for (int b = 0; b < NrBanks; b++) begin
      for (int unsigned off = 0; off < NumInp; off++) begin
        idx = (32'(rr_q[b]) + off) % NumInp;
        if (!bank_gnt[b] && tcdm_req_q_valid_i[idx] && (req_bank[idx] == BankW'(b))) begin
          bank_gnt[b] = 1'b1;
          bank_win[b] = PtrW'(idx);
        end
      end
      if (bank_gnt[b]) begin
        rr_d[b] = (bank_win[b] == PtrW'(NumInp - 1)) ? '0 : bank_win[b] + PtrW'(1);
      end
    end
  end

  always_comb begin
    tcdm_req_q_ready_o = '0;
    for (int i = 0; i < NumInp; i++) begin
      tcdm_req_q_ready_o[i] = tcdm_req_q_valid_i[i] && bank_gnt[req_bank[i]]
                              && (bank_win[req_bank[i]] == PtrW'(i));
    end
  end

  // SRAM banks have no reset; granted writes commit even while reset is asserted
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NrBanks; b++) begin
      if (bank_gnt[b] && tcdm_req_write_i[bank_win[b]]) begin
        for (int k = 0; k < StrbWidth; k++) begin
          if (tcdm_req_strb_i[bank_win[b]][k]) begin
            mem[b][req_row[bank_win[b]]][8*k +: 8] <= tcdm_req_data_i[bank_win[b]][8*k +: 8];
          end
        end
      end
    end
  end

  // One-cycle response path; write responses return zero data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tcdm_rsp_p_valid_o <= '0;
      tcdm_rsp_data_o    <= '0;
      rr_q               <= '0;
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < NumInp; i++) begin
        tcdm_rsp_p_valid_o[i] <= tcdm_req_q_ready_o[i];
        if (tcdm_req_q_ready_o[i]) begin
          tcdm_rsp_data_o[i] <= tcdm_req_write_i[i] ? '0 : mem[req_bank[i]][req_row[i]];
        end
      end
    end
  end

`ifdef TCDM_CONFLICT_CNT_EN
  logic [NumInp-1:0][CntWidth-1:0] cnt_q;

  // Saturating count of cycles a valid request was held off by arbitration
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        if (tcdm_req_q_valid_i[i] && !tcdm_req_q_ready_o[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        end
      end
    end
  end

  assign tcdm_conflict_cnt_o = cnt_q;
`else
  assign tcdm_conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tcdm_banked_xbar.sv
// Directed self-checking bench for tcdm_banked_xbar with default parameters.
module tb_tcdm_banked_xbar;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 12;
  localparam int unsigned NI = 2;
  localparam int unsigned CW = 16;

  logic                    clk;
  logic                    rst_n;
  logic [NI-1:0]           valid;
  logic [NI-1:0]           write;
  logic [NI-1:0][AW-1:0]   addr;
  logic [NI-1:0][DW-1:0]   wdata;
  logic [NI-1:0][DW/8-1:0] strb;
  logic [NI-1:0]           ready;
  logic [NI-1:0]           p_valid;
  logic [NI-1:0][DW-1:0]   rdata;
  logic [NI-1:0][CW-1:0]   cnt;

  int n_cmp;
  int n_err;

  tcdm_banked_xbar dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .tcdm_req_q_valid_i  (valid),
    .tcdm_req_write_i    (write),
    .tcdm_req_addr_i     (addr),
    .tcdm_req_data_i     (wdata),
    .tcdm_req_strb_i     (strb),
    .tcdm_req_q_ready_o  (ready),
    .tcdm_rsp_p_valid_o  (p_valid),
    .tcdm_rsp_data_o     (rdata),
    .tcdm_conflict_cnt_o (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = '0;
    write = '0;
  endtask

  task automatic drive(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    valid[p] = 1'b1;
    write[p] = w;
    addr[p]  = a;
    wdata[p] = d;
    strb[p]  = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    addr  = '0;
    wdata = '0;
    strb  = '0;
    step();
    step();
    n_cmp++; if (p_valid !== 2'b00) begin n_err++; $display("FAIL reset_pvalid got %b want 00", p_valid); end
    n_cmp++; if (rdata !== '0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_cmp++; if (ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", ready); end
    n_cmp++; if (cnt !== '0) begin n_err++; $display("FAIL reset_cnt got %h want 0", cnt); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 12'h000, 64'h1122334455667788, 8'hFF);
    @(negedge clk);
    n_cmp++; if (ready !== 2'b01) begin n_err++; $display("FAIL wr_ready got %b want 01", ready); end
    step();
    n_cmp++; if (p_valid !== 2'b01) begin n_err++; $display("FAIL wr_pvalid got %b want 01", p_valid); end
    n_cmp++; if (rdata[0] !== 64'h0) begin n_err++; $display("FAIL wr_rdata got %h want 0", rdata[0]); end
    drive(0, 1'b0, 12'h000, 64'h0, 8'h00);
    step();
    n_cmp++; if (p_valid !== 2'b01) begin n_err++; $display("FAIL rd_pvalid got %b want 01", p_valid); end
    n_cmp++; if (rdata[0] !== 64'h1122334455667788) begin n_err++; $display("FAIL rd_data got %h want 1122334455667788", rdata[0]); end
    idle();
    step();
    n_cmp++; if (p_valid !== 2'b00) begin n_err++; $display("FAIL idle_pvalid got %b want 00", p_valid); end
    n_cmp++; if (rdata[0] !== 64'h1122334455667788) begin n_err++; $display("FAIL hold_rdata got %h want 1122334455667788", rdata[0]); end
  endtask

  task automatic test_partial_strobe();
    drive(0, 1'b1, 12'h000, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    step();
    drive(0, 1'b0, 12'h000, 64'h0, 8'h00);
    step();
    n_cmp++; if (rdata[0] !== 64'h11223344AAAAAAAA) begin n_err++; $display("FAIL strb_data got %h want 11223344AAAAAAAA", rdata[0]); end
    idle();
    step();
  endtask

  task automatic test_parallel_banks();
    drive(1, 1'b1, 12'h008, 64'hDEADBEEFCAFEF00D, 8'hFF);
    step();
    idle();
    drive(0, 1'b0, 12'h000, 64'h0, 8'h00);
    drive(1, 1'b0, 12'h008, 64'h0, 8'h00);
    @(negedge clk);
    n_cmp++; if (ready !== 2'b11) begin n_err++; $display("FAIL par_ready got %b want 11", ready); end
    step();
    n_cmp++; if (p_valid !== 2'b11) begin n_err++; $display("FAIL par_pvalid got %b want 11", p_valid); end
    n_cmp++; if (rdata[0] !== 64'h11223344AAAAAAAA) begin n_err++; $display("FAIL par_data0 got %h want 11223344AAAAAAAA", rdata[0]); end
    n_cmp++; if (rdata[1] !== 64'hDEADBEEFCAFEF00D) begin n_err++; $display("FAIL par_data1 got %h want DEADBEEFCAFEF00D", rdata[1]); end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    drive(0, 1'b1, 12'h018, 64'h0F0E0D0C0B0A0908, 8'hFF);
    step();
    n_cmp++; if (p_valid !== 2'b01) begin n_err++; $display("FAIL b2b_wr_pvalid got %b want 01", p_valid); end
    drive(0, 1'b0, 12'h018, 64'h0, 8'h00);
    step();
    n_cmp++; if (rdata[0] !== 64'h0F0E0D0C0B0A0908) begin n_err++; $display("FAIL raw_data got %h want 0F0E0D0C0B0A0908", rdata[0]); end
    drive(0, 1'b0, 12'h008, 64'h0, 8'h00);
    step();
    n_cmp++; if (p_valid !== 2'b01) begin n_err++; $display("FAIL b2b_pvalid got %b want 01", p_valid); end
    n_cmp++; if (rdata[0] !== 64'hDEADBEEFCAFEF00D) begin n_err++; $display("FAIL b2b_data got %h want DEADBEEFCAFEF00D", rdata[0]); end
    drive(0, 1'b1, 12'h040, 64'h0123456789ABCDEF, 8'hFF);
    step();
    idle();
    step();
  endtask

  task automatic test_conflict();
    logic [NI-1:0]  exp_rdy;
    logic [CW-1:0]  exp_cnt;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(0, 1'b0, 12'h040, 64'h0, 8'h00);
    drive(1, 1'b0, 12'h040, 64'h0, 8'h00);
    for (int k = 0; k < 10; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      n_cmp++; if (ready !== exp_rdy) begin n_err++; $display("FAIL conf_ready[%0d] got %b want %b", k, ready, exp_rdy); end
      step();
      n_cmp++; if (p_valid !== exp_rdy) begin n_err++; $display("FAIL conf_pvalid[%0d] got %b want %b", k, p_valid, exp_rdy); end
      n_cmp++; if (rdata[k % 2] !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL conf_data[%0d] got %h want 0123456789ABCDEF", k, rdata[k % 2]); end
    end
    idle();
`ifdef TCDM_CONFLICT_CNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    n_cmp++; if (cnt[0] !== exp_cnt) begin n_err++; $display("FAIL conf_cnt0 got %0d want %0d", cnt[0], exp_cnt); end
    n_cmp++; if (cnt[1] !== exp_cnt) begin n_err++; $display("FAIL conf_cnt1 got %0d want %0d", cnt[1], exp_cnt); end
    step();
  endtask

  task automatic test_reset_midop();
    // Port 0 read granted, then reset in the following cycle while port 1 writes bank 2
    drive(0, 1'b0, 12'h000, 64'h0, 8'h00);
    step();
    n_cmp++; if (p_valid !== 2'b01) begin n_err++; $display("FAIL mid_pvalid_pre got %b want 01", p_valid); end
    idle();
    rst_n = 1'b0;
    drive(1, 1'b1, 12'h010, 64'h5555666677778888, 8'hFF);
    step();
    n_cmp++; if (p_valid !== 2'b00) begin n_err++; $display("FAIL mid_pvalid got %b want 00", p_valid); end
    n_cmp++; if (rdata !== '0) begin n_err++; $display("FAIL mid_rdata got %h want 0", rdata); end
    n_cmp++; if (cnt !== '0) begin n_err++; $display("FAIL mid_cnt got %h want 0", cnt); end
    rst_n = 1'b1;
    idle();
    drive(0, 1'b0, 12'h040, 64'h0, 8'h00);
    drive(1, 1'b0, 12'h040, 64'h0, 8'h00);
    @(negedge clk);
    n_cmp++; if (ready !== 2'b01) begin n_err++; $display("FAIL mid_rrptr got %b want 01", ready); end
    step();
    idle();
    drive(0, 1'b0, 12'h000, 64'h0, 8'h00);
    drive(1, 1'b0, 12'h010, 64'h0, 8'h00);
    step();
    n_cmp++; if (rdata[0] !== 64'h11223344AAAAAAAA) begin n_err++; $display("FAIL mid_keep got %h want 11223344AAAAAAAA", rdata[0]); end
    n_cmp++; if (rdata[1] !== 64'h5555666677778888) begin n_err++; $display("FAIL mid_rstwr got %h want 5555666677778888", rdata[1]); end
    idle();
    step();
  endtask

  task automatic test_addr_wrap();
    logic [31:0] wide;
    wide = 32'h0000_1000;
    drive(0, 1'b0, AW'(wide), 64'h0, 8'h00);
    step();
    n_cmp++; if (p_valid !== 2'b01) begin n_err++; $display("FAIL wrap_pvalid got %b want 01", p_valid); end
    n_cmp++; if (rdata[0] !== 64'h11223344AAAAAAAA) begin n_err++; $display("FAIL wrap_data got %h want 11223344AAAAAAAA", rdata[0]); end
    idle();
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_parallel_banks();
    test_back_to_back();
    test_conflict();
    test_reset_midop();
    test_addr_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
